// File: rtl/per2apb_pkg.sv
// Shared types and constants for the peripheral-interconnect to APB3 bridge.
package per2apb_pkg;

    // Bridge FSM: idle/grant, APB SETUP, APB ACCESS, one-cycle response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Response opcode seen by the interconnect.
    localparam logic OPC_OK  = 1'b0;
    localparam logic OPC_ERR = 1'b1;

    // APB3 has no write strobes, so only full-word writes can be forwarded.
    localparam logic [3:0] FULL_BE = 4'hF;

    // ACCESS-phase cycle limit used when the instantiator does not override it.
    localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/per2apb_bridge.sv
// Peripheral-interconnect slave to APB3 master bridge. One request is accepted
// at a time; it is turned into an APB SETUP/ACCESS transfer and answered with a
// single-cycle r_valid response carrying read data, error status and the ID.
module per2apb_bridge
    import per2apb_pkg::*;
#(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 5,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      per_slave_req_i,
    input  logic [PER_ADDR_WIDTH-1:0] per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [ID_WIDTH-1:0]       per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,

    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // Counter must be able to hold the limit itself; keep at least one bit.
    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Abort is decided in the cycle whose increment would reach the limit.
    localparam int LIMIT_M1 = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT_M1 = CNT_WIDTH'(LIMIT_M1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    state_e                    state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      access_done, access_timeout;
    logic                      req_accept;

    // The APB address/data/direction registers double as the request latches.
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic                      r_valid_q, r_valid_d;
    logic                      r_opc_q, r_opc_d;
    logic [ID_WIDTH-1:0]       r_id_q, r_id_d;
    logic [31:0]               r_rdata_q, r_rdata_d;

    logic [APB_ADDR_WIDTH-1:0] add_apb;
    logic                      unused_add;

    // Narrow the request address to PADDR, or zero-extend it when PADDR is wider.
    generate
        if (APB_ADDR_WIDTH <= PER_ADDR_WIDTH) begin : g_addr_trunc
            assign add_apb = per_slave_add_i[APB_ADDR_WIDTH-1:0];
        end else begin : g_addr_zext
            assign add_apb = {{(APB_ADDR_WIDTH - PER_ADDR_WIDTH){1'b0}}, per_slave_add_i};
        end
    endgenerate

    // Upper address bits beyond PADDR are intentionally dropped.
    assign unused_add = ^per_slave_add_i;

    assign req_accept = (state_q == IDLE) && per_slave_req_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; PREADY takes priority over the timeout abort.
    always_comb begin
        state_d        = state_q;
        access_done    = 1'b0;
        access_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (per_slave_req_i) begin
                    if (per_slave_we_i && (per_slave_be_i != FULL_BE)) begin
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    access_done = 1'b1;
                    state_d     = RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT_M1)) begin
                    access_timeout = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output/datapath logic: registered outputs are computed from the next state
    // so PSEL/PENABLE/r_valid line up with the SETUP/ACCESS/RESP cycles.
    always_comb begin
        per_slave_gnt_o = req_accept && !rst_i;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        id_d      = id_q;
        psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        penable_d = (state_d == ACCESS);
        r_valid_d = (state_d == RESP);
        r_opc_d   = r_opc_q;
        r_id_d    = r_id_q;
        r_rdata_d = r_rdata_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_accept) begin
                    paddr_d  = add_apb;
                    pwdata_d = per_slave_wdata_i;
                    pwrite_d = per_slave_we_i;
                    id_d     = per_slave_id_i;
                    // Partial-byte writes are refused without touching APB.
                    if (state_d == RESP) begin
                        r_opc_d   = OPC_ERR;
                        r_rdata_d = '0;
                        r_id_d    = per_slave_id_i;
                    end
                end
            end
            ACCESS: begin
                if (!PREADY) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (access_done) begin
                    r_opc_d   = PSLVERR;
                    r_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                    r_id_d    = id_q;
                end else if (access_timeout) begin
                    r_opc_d   = OPC_ERR;
                    r_rdata_d = '0;
                    r_id_d    = id_q;
                end
            end
            RESP: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath and registered-output flops; reset clears everything so an
    // aborted transfer never produces a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            id_q      <= '0;
            r_valid_q <= 1'b0;
            r_opc_q   <= OPC_OK;
            r_id_q    <= '0;
            r_rdata_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            id_q      <= id_d;
            r_valid_q <= r_valid_d;
            r_opc_q   <= r_opc_d;
            r_id_q    <= r_id_d;
            r_rdata_q <= r_rdata_d;
        end
    end

    assign PADDR               = paddr_q;
    assign PWDATA              = pwdata_q;
    assign PWRITE              = pwrite_q;
    assign PSEL                = psel_q;
    assign PENABLE             = penable_q;
    assign per_slave_r_valid_o = r_valid_q;
    assign per_slave_r_opc_o   = r_opc_q;
    assign per_slave_r_id_o    = r_id_q;
    assign per_slave_r_rdata_o = r_rdata_q;

endmodule

// File: tb/tb_per2apb_bridge.sv
// Directed testbench for per2apb_bridge (TIMEOUT_CYCLES = 4).
module tb_per2apb_bridge;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  id;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [4:0]  r_id;
    logic [31:0] r_rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    per2apb_bridge #(
        .PER_ADDR_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .ID_WIDTH       (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .per_slave_req_i     (req),
        .per_slave_add_i     (add),
        .per_slave_we_i      (we),
        .per_slave_wdata_i   (wdata),
        .per_slave_be_i      (be),
        .per_slave_id_i      (id),
        .per_slave_gnt_o     (gnt),
        .per_slave_r_valid_o (r_valid),
        .per_slave_r_opc_o   (r_opc),
        .per_slave_r_id_o    (r_id),
        .per_slave_r_rdata_o (r_rdata),
        .PADDR               (paddr),
        .PWDATA              (pwdata),
        .PWRITE              (pwrite),
        .PSEL                (psel),
        .PENABLE             (penable),
        .PRDATA              (prdata),
        .PREADY              (pready),
        .PSLVERR             (pslverr)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req = 1'b1; add = 32'h1A10_0000; we = 1'b1; wdata = 32'hFFFF_FFFF;
        be = 4'hF; id = 5'd1; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        checks++;
        if ({psel, penable, pwrite, r_valid, r_opc} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {psel, penable, pwrite, r_valid, r_opc});
        end
        checks++;
        if ({paddr, pwdata, r_rdata, r_id} !== 101'b0) begin
            errors++; $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h rid=%h expected all 0", paddr, pwdata, r_rdata, r_id);
        end
        req = 1'b0; rst_i = 1'b0;
        tick();
        $display("txn reset: done");
    endtask

    task automatic test_read();
        req = 1'b1; add = 32'h1A10_2004; we = 1'b0; wdata = 32'h0; be = 4'hF; id = 5'd5;
        pready = 1'b1; prdata = 32'hCAFE_0001; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL read_gnt: got %b expected 1", gnt); end
        checks++;
        if (psel !== 1'b0) begin errors++; $display("FAIL read_c0_psel: got %b expected 0", psel); end
        tick(); req = 1'b0; #1;
        checks++;
        if ({psel, penable, pwrite, gnt} !== 4'b1000) begin
            errors++; $display("FAIL read_setup: psel/penable/pwrite/gnt got %b expected 1000", {psel, penable, pwrite, gnt});
        end
        checks++;
        if (paddr !== 32'h1A10_2004) begin errors++; $display("FAIL read_paddr: got %h expected 1a102004", paddr); end
        tick();
        checks++;
        if ({psel, penable, r_valid} !== 3'b110) begin
            errors++; $display("FAIL read_access: psel/penable/r_valid got %b expected 110", {psel, penable, r_valid});
        end
        tick();
        checks++;
        if ({r_valid, r_opc, psel} !== 3'b100) begin
            errors++; $display("FAIL read_resp_ctrl: r_valid/opc/psel got %b expected 100", {r_valid, r_opc, psel});
        end
        checks++;
        if (r_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL read_rdata: got %h expected cafe0001", r_rdata); end
        checks++;
        if (r_id !== 5'd5) begin errors++; $display("FAIL read_rid: got %0d expected 5", r_id); end
        tick();
        checks++;
        if (r_valid !== 1'b0) begin errors++; $display("FAIL read_rvalid_single: got %b expected 0", r_valid); end
        $display("txn read addr=1a102004 id=5: rdata=%h opc=%b", 32'hCAFE_0001, 1'b0);
    endtask

    // Three PREADY=0 ACCESS cycles; PREADY arrives in the cycle the counter sits
    // one below the limit, so it must complete normally.
    task automatic test_write_wait();
        req = 1'b1; add = 32'h1A10_2008; we = 1'b1; wdata = 32'h1234_5678; be = 4'hF; id = 5'd9;
        pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL write_gnt: got %b expected 1", gnt); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            req = 1'b0;
            pready = (c == 5);
            #1;
            checks++;
            if ({psel, penable, pwrite, r_valid} !== {1'b1, (c >= 2), 1'b1, 1'b0}) begin
                errors++; $display("FAIL write_ctrl_c%0d: psel/penable/pwrite/r_valid got %b expected %b",
                                   c, {psel, penable, pwrite, r_valid}, {1'b1, (c >= 2), 1'b1, 1'b0});
            end
            checks++;
            if ({paddr, pwdata} !== {32'h1A10_2008, 32'h1234_5678}) begin
                errors++; $display("FAIL write_stable_c%0d: paddr=%h pwdata=%h expected 1a102008 12345678", c, paddr, pwdata);
            end
        end
        tick();
        pready = 1'b0;
        checks++;
        if ({r_valid, r_opc, psel, penable} !== 4'b1000) begin
            errors++; $display("FAIL write_resp_ctrl: r_valid/opc/psel/penable got %b expected 1000", {r_valid, r_opc, psel, penable});
        end
        checks++;
        if ({r_rdata, r_id} !== {32'h0, 5'd9}) begin
            errors++; $display("FAIL write_resp_data: rdata=%h rid=%0d expected 0 9", r_rdata, r_id);
        end
        tick();
        checks++;
        if (r_valid !== 1'b0) begin errors++; $display("FAIL write_rvalid_single: got %b expected 0", r_valid); end
        $display("txn write addr=1a102008 data=12345678 waits=3 id=9: opc=0");
    endtask

    task automatic test_partial_be();
        req = 1'b1; add = 32'h1A10_2010; we = 1'b1; wdata = 32'hAAAA_5555; be = 4'h3; id = 5'd3;
        pready = 1'b1; prdata = 32'h1111_2222; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL be_gnt: got %b expected 1", gnt); end
        tick(); req = 1'b0; #1;
        checks++;
        if ({r_valid, r_opc, psel, penable} !== 4'b1100) begin
            errors++; $display("FAIL be_resp_ctrl: r_valid/opc/psel/penable got %b expected 1100", {r_valid, r_opc, psel, penable});
        end
        checks++;
        if ({r_rdata, r_id} !== {32'h0, 5'd3}) begin
            errors++; $display("FAIL be_resp_data: rdata=%h rid=%0d expected 0 3", r_rdata, r_id);
        end
        tick();
        checks++;
        if ({r_valid, psel} !== 2'b00) begin
            errors++; $display("FAIL be_after: r_valid/psel got %b expected 00", {r_valid, psel});
        end
        $display("txn partial write be=3 id=3: opc=1 no apb");
    endtask

    task automatic test_slverr();
        req = 1'b1; add = 32'h1A10_200C; we = 1'b0; be = 4'hF; id = 5'd7;
        pready = 1'b1; prdata = 32'hBAD0_0BAD; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL slverr_gnt: got %b expected 1", gnt); end
        tick(); req = 1'b0;
        tick(); pslverr = 1'b1; #1;
        checks++;
        if ({psel, penable} !== 2'b11) begin
            errors++; $display("FAIL slverr_access: psel/penable got %b expected 11", {psel, penable});
        end
        tick(); pslverr = 1'b0; #1;
        checks++;
        if ({r_valid, r_opc} !== 2'b11) begin
            errors++; $display("FAIL slverr_resp_ctrl: r_valid/opc got %b expected 11", {r_valid, r_opc});
        end
        checks++;
        if ({r_rdata, r_id} !== {32'hBAD0_0BAD, 5'd7}) begin
            errors++; $display("FAIL slverr_resp_data: rdata=%h rid=%0d expected bad00bad 7", r_rdata, r_id);
        end
        tick();
        $display("txn read slverr id=7: opc=1 rdata=bad00bad");
    endtask

    task automatic test_timeout_back_to_back();
        req = 1'b1; add = 32'h1A10_2020; we = 1'b0; be = 4'hF; id = 5'h1F;
        pready = 1'b0; prdata = 32'h7777_7777; pslverr = 1'b0;
        #1;
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL to_gnt: got %b expected 1", gnt); end
        tick(); req = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            checks++;
            if ({psel, penable, r_valid} !== 3'b110) begin
                errors++; $display("FAIL to_access_c%0d: psel/penable/r_valid got %b expected 110", c, {psel, penable, r_valid});
            end
        end
        tick();
        // Second request presented during RESP: must wait one cycle for grant.
        req = 1'b1; add = 32'h1A10_2024; id = 5'd2; prdata = 32'h0000_55AA; #1;
        checks++;
        if ({r_valid, r_opc, psel, penable, gnt} !== 5'b11000) begin
            errors++; $display("FAIL to_resp_ctrl: r_valid/opc/psel/penable/gnt got %b expected 11000",
                               {r_valid, r_opc, psel, penable, gnt});
        end
        checks++;
        if ({r_rdata, r_id} !== {32'h0, 5'h1F}) begin
            errors++; $display("FAIL to_resp_data: rdata=%h rid=%0d expected 0 31", r_rdata, r_id);
        end
        tick();
        pready = 1'b1;
        checks++;
        if ({gnt, r_valid} !== 2'b10) begin
            errors++; $display("FAIL b2b_gnt: gnt/r_valid got %b expected 10", {gnt, r_valid});
        end
        tick(); req = 1'b0;
        tick();
        tick();
        checks++;
        if ({r_valid, r_opc, r_rdata, r_id} !== {1'b1, 1'b0, 32'h0000_55AA, 5'd2}) begin
            errors++; $display("FAIL b2b_resp: r_valid=%b opc=%b rdata=%h rid=%0d expected 1 0 000055aa 2",
                               r_valid, r_opc, r_rdata, r_id);
        end
        tick();
        $display("txn timeout id=31: opc=1; back-to-back read id=2: rdata=000055aa");
    endtask

    task automatic test_reset_mid();
        req = 1'b1; add = 32'h1A10_3000; we = 1'b0; be = 4'hF; id = 5'd6;
        pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
        tick(); req = 1'b0;
        tick();
        rst_i = 1'b1; req = 1'b1; add = 32'h1A10_3004; id = 5'd4; pready = 1'b1; prdata = 32'h0000_4444; #1;
        checks++;
        if ({psel, penable, gnt} !== 3'b110) begin
            errors++; $display("FAIL rstmid_pre: psel/penable/gnt got %b expected 110", {psel, penable, gnt});
        end
        tick();
        rst_i = 1'b0; #1;
        checks++;
        if ({psel, penable, r_valid, paddr} !== 35'b0) begin
            errors++; $display("FAIL rstmid_clear: psel/penable/r_valid=%b paddr=%h expected 000 0",
                               {psel, penable, r_valid}, paddr);
        end
        checks++;
        if (gnt !== 1'b1) begin errors++; $display("FAIL rstmid_regnt: got %b expected 1", gnt); end
        tick(); req = 1'b0; #1;
        checks++;
        if ({psel, penable, r_valid, paddr} !== {3'b100, 32'h1A10_3004}) begin
            errors++; $display("FAIL rstmid_setup: psel/penable/r_valid=%b paddr=%h expected 100 1a103004",
                               {psel, penable, r_valid}, paddr);
        end
        tick();
        checks++;
        if (r_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noresp: got %b expected 0", r_valid); end
        tick();
        checks++;
        if ({r_valid, r_opc, r_rdata, r_id} !== {1'b1, 1'b0, 32'h0000_4444, 5'd4}) begin
            errors++; $display("FAIL rstmid_resp: r_valid=%b opc=%b rdata=%h rid=%0d expected 1 0 00004444 4",
                               r_valid, r_opc, r_rdata, r_id);
        end
        tick();
        $display("txn reset mid-access, new read id=4: rdata=00004444");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_wait();
        test_partial_be();
        test_slverr();
        test_timeout_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
